// File: rtl/scan_chain_master.sv
// scan_chain_master
// Initiator side of the memory-bank scan chain. One swap shifts the whole
// chain once. Each host byte goes in LSB first. Each byte that falls off the
// chain tail is assembled and returned on the output stream.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-low reset
//   start               : one-cycle swap request, ignored while busy
//   in_data/valid/ready : host-to-chain byte stream
//   out_data/valid/ready: chain-to-host byte stream
//   busy, done          : swap in progress / one-cycle completion pulse
//   scan_enable/scan_in : chain shift strobe and serial data into the chain
//   scan_out            : serial data from the chain tail
//   crc                 : (SCAN_CRC_EN only) CRC-8/0x07 over accepted out bytes
//
// Optional feature macro: SCAN_CRC_EN
module scan_chain_master #(
    parameter int CHAIN_LEN = 256,
    parameter int CNT_WIDTH = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       scan_enable,
    output logic       scan_in,
    input  logic       scan_out
`ifdef SCAN_CRC_EN
    ,
    output logic [7:0] crc
`endif
);

    localparam int NUM_BYTES = CHAIN_LEN / 8;
    localparam logic [CNT_WIDTH-1:0] LAST_BYTE = CNT_WIDTH'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_PUSH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic [7:0]             tx_r, tx_s;
    logic [7:0]             rx_r, rx_s;
    logic [2:0]             bit_cnt_r, bit_cnt_s;
    logic [CNT_WIDTH-1:0]   byte_cnt_r, byte_cnt_s;
    logic [7:0]             out_data_s;
    logic                   in_ready_s, out_valid_s, busy_s, done_s;
    logic                   scan_enable_s, scan_in_s;
    logic                   in_fire_s, out_fire_s;

    // in_ready/out_valid are registered copies of the state decode, so the
    // handshakes can be formed directly from the output ports.
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

`ifdef SCAN_CRC_EN
    // CRC-8, polynomial 0x07, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_fire_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r == 3'd7) begin
                    state_s = ST_PUSH;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_PUSH: begin
                if (out_fire_s && (byte_cnt_r == LAST_BYTE)) begin
                    state_s = ST_DONE;
                end else if (out_fire_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_PUSH;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath next values: shift registers, counters and the output byte.
    always_comb begin
        tx_s       = tx_r;
        rx_s       = rx_r;
        bit_cnt_s  = bit_cnt_r;
        byte_cnt_s = byte_cnt_r;
        out_data_s = out_data;
        case (state_r)
            ST_IDLE: begin
                bit_cnt_s  = 3'd0;
                byte_cnt_s = '0;
            end
            ST_LOAD: begin
                if (in_fire_s) begin
                    tx_s      = in_data;
                    bit_cnt_s = 3'd0;
                end else begin
                    tx_s = tx_r;
                end
            end
            ST_SHIFT: begin
                // The chain moves on this same edge, so scan_out still shows
                // the old tail bit; the first bit captured ends up in rx[0].
                tx_s      = {1'b0, tx_r[7:1]};
                rx_s      = {scan_out, rx_r[7:1]};
                bit_cnt_s = bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    out_data_s = {scan_out, rx_r[7:1]};
                end else begin
                    out_data_s = out_data;
                end
            end
            ST_PUSH: begin
                if (out_fire_s) begin
                    byte_cnt_s = byte_cnt_r + CNT_WIDTH'(1);
                end else begin
                    byte_cnt_s = byte_cnt_r;
                end
            end
            ST_DONE: byte_cnt_s = '0;
            default: begin
                bit_cnt_s  = 3'd0;
                byte_cnt_s = '0;
            end
        endcase
    end

    // Output decode from the next state. These values are registered, so
    // every output is glitch-free and lines up with the state it belongs to.
    always_comb begin
        in_ready_s    = 1'b0;
        out_valid_s   = 1'b0;
        busy_s        = 1'b1;
        done_s        = 1'b0;
        scan_enable_s = 1'b0;
        scan_in_s     = 1'b0;
        case (state_s)
            ST_IDLE:  busy_s = 1'b0;
            ST_LOAD:  in_ready_s = 1'b1;
            ST_SHIFT: begin
                scan_enable_s = 1'b1;
                scan_in_s     = tx_s[0];
            end
            ST_PUSH:  out_valid_s = 1'b1;
            ST_DONE:  done_s = 1'b1;
            default:  busy_s = 1'b0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_r        <= 8'h00;
            rx_r        <= 8'h00;
            bit_cnt_r   <= 3'd0;
            byte_cnt_r  <= '0;
            out_data    <= 8'h00;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            scan_enable <= 1'b0;
            scan_in     <= 1'b0;
        end else begin
            tx_r        <= tx_s;
            rx_r        <= rx_s;
            bit_cnt_r   <= bit_cnt_s;
            byte_cnt_r  <= byte_cnt_s;
            out_data    <= out_data_s;
            in_ready    <= in_ready_s;
            out_valid   <= out_valid_s;
            busy        <= busy_s;
            done        <= done_s;
            scan_enable <= scan_enable_s;
            scan_in     <= scan_in_s;
        end
    end

`ifdef SCAN_CRC_EN
    // Running CRC of accepted output bytes; restarts when a swap is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= 8'h00;
        end else if ((state_r == ST_IDLE) && start) begin
            crc <= 8'h00;
        end else if (out_fire_s) begin
            crc <= crc8_byte(crc, out_data);
        end else begin
            crc <= crc;
        end
    end
`endif

endmodule
